fdc_sd_arb: RTL and testbench

FDC_SD_ARB -- requirements
Module: fdc_sd_arb

---
 rtl/fdc_pkg.sv | 6 +
 rtl/fdc_sd_arb_if.sv | 22 ++
 rtl/fdc_rr_pick.sv | 10 +
 rtl/fdc_sd_arb.sv | 86 ++++++++
 tb/tb_fdc_sd_arb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fdc_pkg.sv
// fdc_pkg: shared FSM/op encodings and default host timeout for the floppy SD arbiter.
package fdc_pkg;
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
    localparam logic [23:0] TIMEOUT_DEF = 24'd2000000;
endpackage

// File: rtl/fdc_sd_arb_if.sv
// fdc_sd_arb_if: FDC-side request/ack and host-side request/ack bundle.
interface fdc_sd_arb_if;
    logic [31:0] fdc_lba;
    logic [1:0]  fdc_rd;
    logic [1:0]  fdc_wr;
    logic        fdc_ack;
    logic [31:0] host_lba;
    logic        host_rd;
    logic        host_wr;
    logic        host_drv;
    logic        host_ack;
    logic        busy;
    logic        err;
    modport slave (
        input  fdc_lba, fdc_rd, fdc_wr, host_ack,
        output fdc_ack, host_lba, host_rd, host_wr, host_drv, busy, err
    );
    modport master (
        output fdc_lba, fdc_rd, fdc_wr, host_ack,
        input  fdc_ack, host_lba, host_rd, host_wr, host_drv, busy, err
    );
endinterface

// File: rtl/fdc_rr_pick.sv
// fdc_rr_pick: combinational 2-way round-robin picker; on contention the drive not served last wins.
module fdc_rr_pick (
    input  logic [1:0] pending,
    input  logic       last,
    output logic       valid,
    output logic       sel
);
    assign valid = |pending;
    assign sel   = &pending ? ~last : pending[1];
endmodule

// File: rtl/fdc_sd_arb.sv
// fdc_sd_arb: arbitrates two FDC drives' sector read/write requests onto one host channel.
module fdc_sd_arb
    import fdc_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
    input logic          clk_sys,
    input logic          reset,
    fdc_sd_arb_if.slave  bus
);
    state_t      r_state;
    logic        r_rd, r_wr, r_err, r_drv, r_last_drv;
    logic [31:0] r_lba;
    logic [23:0] r_cnt;
    logic [1:0]  w_pend;
    logic        w_valid, w_sel, w_drv_req, w_tmo;
    op_t         w_op;

    assign w_pend    = bus.fdc_rd | bus.fdc_wr;
    assign w_op      = bus.fdc_rd[w_sel] ? OP_RD : OP_WR;
    assign w_drv_req = bus.fdc_rd[r_drv] | bus.fdc_wr[r_drv];
    assign w_tmo     = r_cnt == TIMEOUT - 24'd1;

    fdc_rr_pick u_pick (
        .pending (w_pend),
        .last    (r_last_drv),
        .valid   (w_valid),
        .sel     (w_sel)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_drv      <= 1'b0;
            r_last_drv <= 1'b1;
            r_lba      <= '0;
            r_cnt      <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: if (w_valid) begin
                    r_state <= REQ;
                    r_lba   <= bus.fdc_lba;
                    r_drv   <= w_sel;
                    r_rd    <= w_op == OP_RD;
                    r_wr    <= w_op == OP_WR;
                    r_cnt   <= '0;
                end
                REQ: if (bus.host_ack) begin
                    r_state <= XFER;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                end else if (!w_drv_req) begin
                    r_state <= IDLE;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                end else if (w_tmo) begin
                    r_state    <= IDLE;
                    r_rd       <= 1'b0;
                    r_wr       <= 1'b0;
                    r_err      <= 1'b1;
                    r_last_drv <= r_drv;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 24'd1;
                end
                XFER: if (!bus.host_ack) r_state <= DONE;
                DONE: begin
                    r_state    <= IDLE;
                    r_last_drv <= r_drv;
                end
            endcase
        end
    end

    // fdc_ack is a pass-through so the FDC sees the host strobe with no added latency
    assign bus.fdc_ack  = (r_state == XFER) & bus.host_ack;
    assign bus.host_lba = r_lba;
    assign bus.host_rd  = r_rd;
    assign bus.host_wr  = r_wr;
    assign bus.host_drv = r_drv;
    assign bus.busy     = r_state != IDLE;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_fdc_sd_arb.sv
// tb_fdc_sd_arb: vector table, directed corner sequences and random traffic against a reference model.
module tb_fdc_sd_arb;
    import fdc_pkg::*;
    localparam logic [23:0] TO = 24'd16;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   tests   = 0;
    int   fails   = 0;

    fdc_sd_arb_if bus();
    fdc_sd_arb #(.TIMEOUT(TO)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0]  rd, wr;
        logic [31:0] lba;
        logic        e_rd, e_wr, e_drv, e_busy;
    } vec_t;
    vec_t vt[9];

    // reference model: grants, waiting age, served history
    int          m_ph, m_age;
    logic        m_drv, m_last, m_rd, m_wr, m_err;
    logic [31:0] m_lba;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.fdc_rd = 2'b00; bus.fdc_wr = 2'b00; bus.fdc_lba = '0; bus.host_ack = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        #1;
    endtask

    task automatic serve();
        bus.host_ack = 1'b1; tick();
        bus.host_ack = 1'b0; tick();
        tick();
    endtask

    function automatic logic [39:0] outs();
        return {bus.host_rd, bus.host_wr, bus.host_drv, bus.busy, bus.err, bus.fdc_ack, 2'b00, bus.host_lba};
    endfunction

    function automatic logic [39:0] mouts();
        return {m_rd, m_wr, m_drv, m_ph != 0, m_err, m_ph == 2 && bus.host_ack, 2'b00, m_lba};
    endfunction

    task automatic model_edge();
        logic [1:0] p;
        logic       d;
        m_err = 1'b0;
        p = bus.fdc_rd | bus.fdc_wr;
        if (m_ph == 0) begin
            if (p != 2'b00) begin
                d = (p == 2'b11) ? !m_last : p[1];
                m_drv = d; m_lba = bus.fdc_lba; m_age = 0; m_ph = 1;
                m_rd = bus.fdc_rd[d]; m_wr = !bus.fdc_rd[d];
            end
        end else if (m_ph == 1) begin
            if (bus.host_ack) begin
                m_ph = 2; m_rd = 1'b0; m_wr = 1'b0;
            end else if (!(bus.fdc_rd[m_drv] | bus.fdc_wr[m_drv])) begin
                m_ph = 0; m_rd = 1'b0; m_wr = 1'b0;
            end else begin
                m_age++;
                if (m_age == int'(TO)) begin
                    m_ph = 0; m_rd = 1'b0; m_wr = 1'b0; m_err = 1'b1; m_last = m_drv;
                end
            end
        end else if (m_ph == 2) begin
            if (!bus.host_ack) m_ph = 3;
        end else begin
            m_last = m_drv; m_ph = 0;
        end
    endtask

    initial begin
        int bias;
        vt[0] = '{2'b00, 2'b00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{2'b01, 2'b00, 32'h11,       1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{2'b10, 2'b00, 32'h22,       1'b1, 1'b0, 1'b1, 1'b1};
        vt[3] = '{2'b00, 2'b01, 32'h33,       1'b0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{2'b11, 2'b00, 32'h44,       1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{2'b10, 2'b10, 32'h55,       1'b1, 1'b0, 1'b1, 1'b1};
        vt[6] = '{2'b00, 2'b11, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[7] = '{2'b01, 2'b10, 32'h77,       1'b1, 1'b0, 1'b0, 1'b1};
        vt[8] = '{2'b10, 2'b01, 32'h88,       1'b0, 1'b1, 1'b0, 1'b1};

        do_reset();
        chk("reset_state", outs(), 40'h0);
        for (int i = 0; i < 9; i++) begin
            do_reset();
            bus.fdc_rd = vt[i].rd; bus.fdc_wr = vt[i].wr; bus.fdc_lba = vt[i].lba;
            tick();
            chk($sformatf("vec%0d_ctl", i), {bus.host_rd, bus.host_wr, bus.host_drv, bus.busy},
                {vt[i].e_rd, vt[i].e_wr, vt[i].e_drv, vt[i].e_busy});
            chk($sformatf("vec%0d_lba", i), bus.host_lba, vt[i].e_busy ? vt[i].lba : 32'h0);
        end

        // single read with delayed host ack
        do_reset();
        bus.fdc_rd = 2'b01; bus.fdc_lba = 32'h10;
        tick();
        chk("rd_grant", {bus.host_rd, bus.host_drv, bus.host_lba}, {1'b1, 1'b0, 32'h10});
        tick(); tick();
        bus.host_ack = 1'b1; #1;
        chk("rd_ack_in_req", bus.fdc_ack, 1'b0);
        tick();
        chk("rd_xfer", {bus.host_rd, bus.fdc_ack, bus.busy}, 3'b011);
        tick(); tick();
        bus.host_ack = 1'b0; bus.fdc_rd = 2'b00; #1;
        chk("rd_ack_fall", bus.fdc_ack, 1'b0);
        tick();
        chk("rd_done", bus.busy, 1'b1);
        tick();
        chk("rd_idle", {bus.busy, bus.host_lba, bus.host_drv}, {1'b0, 32'h10, 1'b0});

        // contention: 0, then 1, then 0
        do_reset();
        bus.fdc_rd = 2'b11;
        tick();
        chk("cont_first", {bus.host_rd, bus.host_drv}, 2'b10);
        serve(); tick();
        chk("cont_second", {bus.host_rd, bus.host_drv}, 2'b11);
        serve(); tick();
        chk("cont_third", {bus.host_rd, bus.host_drv}, 2'b10);

        // same drive read+write: read first, write next arbitration
        do_reset();
        bus.fdc_rd = 2'b10; bus.fdc_wr = 2'b10;
        tick();
        chk("rw_read", {bus.host_rd, bus.host_wr, bus.host_drv}, 3'b101);
        bus.host_ack = 1'b1; tick();
        bus.host_ack = 1'b0; bus.fdc_rd = 2'b00; tick();
        tick(); tick();
        chk("rw_write", {bus.host_rd, bus.host_wr, bus.host_drv}, 3'b011);

        // withdrawal before ack
        bus.fdc_wr = 2'b00;
        tick();
        chk("withdraw", {bus.busy, bus.err, bus.host_wr}, 3'b000);

        // timeout with other drive waiting
        do_reset();
        bus.fdc_rd = 2'b11;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_before", {bus.err, bus.host_rd, bus.busy}, 3'b011);
        tick();
        chk("tmo_err", {bus.err, bus.host_rd, bus.busy}, 3'b100);
        tick();
        chk("tmo_next", {bus.err, bus.host_rd, bus.host_drv}, 3'b011);

        // reset during transfer
        do_reset();
        bus.fdc_rd = 2'b01; bus.fdc_lba = 32'hABCD;
        tick();
        bus.host_ack = 1'b1;
        tick();
        chk("rst_pre", bus.fdc_ack, 1'b1);
        reset = 1'b1; #1;
        chk("rst_async", outs(), 40'h0);
        tick();

        // random traffic against the reference model
        do_reset();
        m_ph = 0; m_age = 0; m_drv = 1'b0; m_last = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_err = 1'b0; m_lba = '0;
        bias = 3;
        for (int c = 0; c < 2000; c++) begin
            if (c % 40 == 0) bias = (c % 120 == 0) ? 0 : (c % 80 == 0) ? 8 : 3;
            if ($urandom_range(0, 5) == 0) begin
                bus.fdc_rd = 2'($urandom); bus.fdc_wr = 2'($urandom); bus.fdc_lba = $urandom;
            end
            bus.host_ack = $urandom_range(0, 9) < bias;
            #1;
            chk($sformatf("rand%0d", c), outs(), mouts());
            @(posedge clk_sys);
            model_edge();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
